// File: rtl/mult_limb_mac_seq.sv
// Sequential limb-based multiply-accumulate: result = a_in * b_in (+ c_in).
// PAR limb partial products are folded into the accumulator each RUN cycle.
module mult_limb_mac_seq #(
  parameter int LIMB   = 16,
  parameter int A_BITS = 130,
  parameter int B_BITS = 128,
  parameter int PAR    = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [A_BITS-1:0]        a_in,
  input  logic [B_BITS-1:0]        b_in,
  input  logic [A_BITS+B_BITS-1:0] c_in,
  input  logic                     add_en,
  input  logic                     abort,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [A_BITS+B_BITS:0]   result
);

  localparam int A_LIMBS = (A_BITS + LIMB - 1) / LIMB;
  localparam int B_LIMBS = (B_BITS + LIMB - 1) / LIMB;
  localparam int TOTAL   = A_LIMBS * B_LIMBS;
  localparam int P_BITS  = A_BITS + B_BITS;
  localparam int SUM_W   = P_BITS + 1;
  localparam int A_W     = A_LIMBS * LIMB;
  localparam int B_W     = B_LIMBS * LIMB;
  localparam int IDX_W   = $clog2(TOTAL + 1);
  localparam int AI_W    = $clog2(A_LIMBS + 1);
  localparam int BJ_W    = $clog2(B_LIMBS + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [A_W-1:0]   a_flat;
  logic [B_W-1:0]   b_flat;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] sum;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic [AI_W-1:0]  ai_q;
  logic [AI_W-1:0]  ai_next;
  logic [BJ_W-1:0]  bj_q;
  logic [BJ_W-1:0]  bj_next;
  logic             last;

  assign in_ready = (state == IDLE) && !abort;

  // ai_q/bj_q track the limb pair of partial idx, so no divider is needed;
  // the walk below steps bj and wraps into ai for each of the PAR partials.
  always_comb begin
    int ai;
    int bj;
    logic [2*LIMB-1:0] pp;
    // NOTE: blocking assignments here chain the PAR additions into one
    // combinational tree; each partial sees the sum of those before it.
    sum = acc;
    ai  = int'(ai_q);
    bj  = int'(bj_q);
    pp  = '0;
    for (int p = 0; p < PAR; p++) begin
      if (int'(idx) + p < TOTAL) begin
        pp  = a_flat[ai*LIMB +: LIMB] * b_flat[bj*LIMB +: LIMB];
        // Each shifted partial is bounded by a*b, so SUM_W bits never truncate it.
        sum = sum + (SUM_W'(pp) << ((ai + bj) * LIMB));
        if (bj == B_LIMBS - 1) begin
          bj = 0;
          ai = ai + 1;
        end else begin
          bj = bj + 1;
        end
      end
    end
    ai_next = AI_W'(ai);
    bj_next = BJ_W'(bj);
  end

  assign last     = (int'(idx) + PAR >= TOTAL);
  assign idx_next = last ? IDX_W'(TOTAL) : idx + IDX_W'(PAR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      acc       <= '0;
      idx       <= '0;
      ai_q      <= '0;
      bj_q      <= '0;
      // NOTE: the operand limbs are plain registers and are cleared like any
      // other state so nothing stale is observable after reset.
      a_flat    <= '0;
      b_flat    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_flat <= A_W'(a_in);
            b_flat <= B_W'(b_in);
            acc    <= add_en ? {1'b0, c_in} : '0;
            idx    <= '0;
            ai_q   <= '0;
            bj_q   <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            busy      <= 1'b0;
            out_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            acc  <= sum;
            idx  <= idx_next;
            ai_q <= ai_next;
            bj_q <= bj_next;
            if (last) begin
              result    <= sum;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (abort || out_ready) begin
            busy      <= 1'b0;
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          busy      <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_limb_mac_seq.sv
// Directed bench for mult_limb_mac_seq: default 130x128 instance plus
// PAR=5, PAR=1 and 64x64/LIMB=32/PAR=3 instances checked against wide arithmetic.
module tb_mult_limb_mac_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic         in_valid, in_ready, add_en, abort, busy, out_valid, out_ready;
  logic [129:0] a_in;
  logic [127:0] b_in;
  logic [257:0] c_in;
  logic [258:0] result;

  // PAR=5 and PAR=1 instances share one stimulus set
  logic         s_valid, s_add;
  logic [129:0] s_a;
  logic [127:0] s_b;
  logic [257:0] s_c;
  logic         p5_ready, p5_busy, p5_valid, p1_ready, p1_busy, p1_valid;
  logic [258:0] p5_result, p1_result;

  // 64x64 instance
  logic         w_valid, w_add, w_ready, w_busy, w_ovalid;
  logic [63:0]  w_a, w_b;
  logic [127:0] w_c;
  logic [128:0] w_result;

  mult_limb_mac_seq u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .add_en(add_en), .abort(abort),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  mult_limb_mac_seq #(.PAR(5)) u_p5 (
    .clk(clk), .reset_n(reset_n), .in_valid(s_valid), .in_ready(p5_ready),
    .a_in(s_a), .b_in(s_b), .c_in(s_c), .add_en(s_add), .abort(1'b0),
    .busy(p5_busy), .out_valid(p5_valid), .out_ready(1'b1), .result(p5_result)
  );

  mult_limb_mac_seq #(.PAR(1)) u_p1 (
    .clk(clk), .reset_n(reset_n), .in_valid(s_valid), .in_ready(p1_ready),
    .a_in(s_a), .b_in(s_b), .c_in(s_c), .add_en(s_add), .abort(1'b0),
    .busy(p1_busy), .out_valid(p1_valid), .out_ready(1'b1), .result(p1_result)
  );

  mult_limb_mac_seq #(.LIMB(32), .A_BITS(64), .B_BITS(64), .PAR(3)) u_w (
    .clk(clk), .reset_n(reset_n), .in_valid(w_valid), .in_ready(w_ready),
    .a_in(w_a), .b_in(w_b), .c_in(w_c), .add_en(w_add), .abort(1'b0),
    .busy(w_busy), .out_valid(w_ovalid), .out_ready(1'b1), .result(w_result)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [258:0] got, input logic [258:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues one operation on the default instance (out_ready assumed high) and
  // watches 60 cycles: latency from the accept edge, busy cycles, valid cycles.
  task automatic run_op(input logic [129:0] a, input logic [127:0] b,
                        input logic [257:0] c, input logic ae,
                        output int lat, output logic [258:0] res,
                        output int bc, output int vc);
    @(negedge clk);
    a_in = a; b_in = b; c_in = c; add_en = ae; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = -1; bc = 0; vc = 0; res = '0;
    for (int e = 0; e < 60; e++) begin
      if (busy) bc++;
      if (out_valid) begin
        vc++;
        if (lat < 0) begin
          lat = e;
          res = result;
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat, bc, vc, n, l5, l1, lw;
    logic [258:0] res, exp, r5, r1, exp_bp;
    logic [128:0] rw, exp_w;
    logic         seen;

    in_valid = 0; add_en = 0; abort = 0; out_ready = 1;
    a_in = '0; b_in = '0; c_in = '0;
    s_valid = 0; s_add = 0; s_a = '0; s_b = '0; s_c = '0;
    w_valid = 0; w_add = 0; w_a = '0; w_b = '0; w_c = '0;

    // reset values
    #12;
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_p5_ready", p5_ready, 1);
    check("rst_p1_ready", p1_ready, 1);
    check("rst_w_ready", w_ready, 1);
    check("rst_other_busy", {p5_busy, p1_busy, w_busy}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: maximum operands, no addend
    exp = (259'(1) << 258) - (259'(1) << 130) - (259'(1) << 128) + 259'(1);
    run_op({130{1'b1}}, {128{1'b1}}, '0, 1'b0, lat, res, bc, vc);
    check("max_result", res, exp);
    check("max_latency", lat, 18);
    check("max_busy_cycles", bc, 19);
    check("max_valid_cycles", vc, 1);

    // 2: MAC small and MAC with carry into bit 258
    run_op(130'd3, 128'd5, 258'd7, 1'b1, lat, res, bc, vc);
    check("mac_small", res, 22);
    check("mac_small_latency", lat, 18);
    exp = 259'(0) - (259'(1) << 130) - (259'(1) << 128);
    run_op({130{1'b1}}, {128{1'b1}}, {258{1'b1}}, 1'b1, lat, res, bc, vc);
    check("mac_carry", res, exp);
    check("mac_carry_bit258", res[258], 1);

    // 3: backpressure for 10 cycles with in_valid pulses ignored
    out_ready = 1'b0;
    exp_bp = 259'd103153760;
    @(negedge clk);
    a_in = 130'h1234; b_in = 128'h5678; c_in = '0; add_en = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_latency", n, 18);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a_in = ~a_in;
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_result", result, exp_bp);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_busy", busy, 0);
    check("bp_release_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    @(negedge clk);
    check("bp_no_spurious_accept", busy, 0);

    // 4a: abort on the 5th RUN cycle, then a fresh operation
    a_in = {130{1'b1}}; b_in = {128{1'b1}}; c_in = '0; add_en = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_result_kept", result, exp_bp);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("abort_no_valid", seen, 0);
    run_op(130'(1) << 129, 128'(1) << 127, '0, 1'b0, lat, res, bc, vc);
    check("after_abort_result", res, 259'(1) << 256);
    check("after_abort_latency", lat, 18);

    // 4b: abort beats accept in IDLE
    @(negedge clk);
    abort = 1'b1; in_valid = 1'b1; a_in = 130'd9; b_in = 128'd9;
    #1;
    check("abort_idle_in_ready", in_ready, 0);
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    check("abort_idle_no_accept", busy, 0);

    // 5: reset in RUN cycle 9
    a_in = 130'd77; b_in = 128'd88; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_result", result, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_mid_in_ready", in_ready, 1);
    run_op(130'hFFFF, 128'hFFFF, 258'd1, 1'b1, lat, res, bc, vc);
    check("after_reset_result", res, 259'h0FFFE0002);

    // 6a: PAR=5 and PAR=1 against wide arithmetic
    for (int it = 0; it < 20; it++) begin
      @(negedge clk);
      if (it == 0) begin
        s_a = {130{1'b1}}; s_b = {128{1'b1}}; s_c = {258{1'b1}}; s_add = 1'b1;
      end else begin
        s_a = 130'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        s_b = {$urandom(), $urandom(), $urandom(), $urandom()};
        s_c = 258'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()});
        s_add = $urandom_range(0, 1) == 1;
      end
      s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      exp = 259'(s_a) * 259'(s_b) + (s_add ? 259'(s_c) : 259'(0));
      l5 = -1; l1 = -1; r5 = '0; r1 = '0;
      for (int e = 0; e < 100 && l1 < 0; e++) begin
        if (p5_valid && l5 < 0) begin
          l5 = e;
          r5 = p5_result;
        end
        if (p1_valid) begin
          l1 = e;
          r1 = p1_result;
        end else begin
          @(negedge clk);
        end
      end
      check("par5_result", r5, exp);
      check("par5_latency", l5, 15);
      check("par1_result", r1, exp);
      check("par1_latency", l1, 72);
    end

    // 6b: LIMB=32, 64x64, PAR=3 -> 4 partials in 2 RUN cycles
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      if (it == 0) begin
        w_a = '1; w_b = '1; w_c = '1; w_add = 1'b1;
      end else begin
        w_a = {$urandom(), $urandom()};
        w_b = {$urandom(), $urandom()};
        w_c = {$urandom(), $urandom(), $urandom(), $urandom()};
        w_add = $urandom_range(0, 1) == 1;
      end
      w_valid = 1'b1;
      @(negedge clk);
      w_valid = 1'b0;
      exp_w = 129'(w_a) * 129'(w_b) + (w_add ? 129'(w_c) : 129'(0));
      lw = -1; rw = '0;
      for (int e = 0; e < 20 && lw < 0; e++) begin
        if (w_ovalid) begin
          lw = e;
          rw = w_result;
        end else begin
          @(negedge clk);
        end
      end
      check("w64_result", rw, exp_w);
      check("w64_latency", lw, 2);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
